axi_dma_copy_master: RTL
========================

Name: axi_dma_copy_master

Overview:
- AXI-style read/write initiator that copies a contiguous block of 32-byte beats from a source address to a destination address over a 256-bit master port.
- Drives the same AW/W/B/AR/R signal set that the simulation memory responder accepts.
- Used by the NPU DMA path and by sim benches to move tensors through the memory model.
- One burst in flight at a time: read a chunk into a local buffer, then write it out, then repeat.

Parameters:
- MAX_BURST, 16, maximum beats per burst; power of two, 1..128; also sets the chunk buffer depth.
- ADDR_W, 64, address width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  copy request valid
- cmd_ready  out  1  engine idle and able to accept a request
- cmd_src  in  64  source byte address; bits [4:0] ignored and forced to 0
- cmd_dst  in  64  destination byte address; bits [4:0] ignored and forced to 0
- cmd_beats  in  24  transfer length in 32-byte beats
- busy  out  1  high from command accept until the done pulse
- done  out  1  one-cycle pulse at completion
- err  out  1  sticky rlast-mismatch flag; cleared on next command accept
- m_axi_awvalid/awready/awaddr[63:0]/awlen[7:0]/awsize[2:0]  AW channel (out/in/out/out/out)
- m_axi_wvalid/wready/wdata[255:0]/wstrb[31:0]/wlast  W channel (out/in/out/out/out)
- m_axi_bvalid/bready  B channel (in/out)
- m_axi_arvalid/arready/araddr[63:0]/arlen[7:0]/arsize[2:0]  AR channel (out/in/out/out/out)
- m_axi_rvalid/rready/rdata[255:0]/rlast  R channel (in/out/in/in)

Behaviour:
- Reset values:
  - All valid/ready outputs 0 except cmd_ready=1.
  - busy=0, done=0, err=0.
  - Addresses, lengths and wdata 0; wstrb all-ones; awsize=arsize=3'd5.
  - FSM returns to IDLE.
- Reset mid-burst aborts immediately. No further handshakes; buffer contents are discarded.
- FSM states: IDLE, SETUP, AR, RD, AW, WR, BR.
- IDLE: cmd_ready=1.
  - On cmd_valid: latch src, dst and remaining=cmd_beats; clear err; set busy.
  - Go to SETUP; if cmd_beats==0, go to IDLE instead and pulse done the next cycle.
- SETUP (1 cycle): chunk = min(remaining, MAX_BURST, beats to next 4KB boundary of src, same for dst). Beats to boundary = (4096 - addr[11:0]) >> 5.
- AR: arvalid=1, araddr=src, arlen=chunk-1. Signals held stable until arready. On handshake go to RD.
- RD: rready=1. Each rvalid beat is written to buffer[beat_idx], beat_idx++.
  - On the chunk-th beat go to AW.
  - If rlast differs from (beat_idx==chunk-1) on any beat, set err. The beat count stays authoritative.
- AW: awvalid=1, awaddr=dst, awlen=chunk-1, held until awready. wvalid stays 0 until the AW handshake completes.
- WR:
  - wvalid=1, wdata=buffer[widx], wstrb=32'hFFFFFFFF, wlast=(widx==chunk-1).
  - Data is held until wready. On handshake widx++.
  - After the last beat go to BR.
- BR: bready=1. On bvalid:
  - src+=chunk*32, dst+=chunk*32, remaining-=chunk.
  - If remaining==0: done pulses next cycle, busy drops with it, go to IDLE. Otherwise go to SETUP.
- Simultaneous events:
  - cmd_valid while busy is ignored (cmd_ready=0).
  - bvalid can arrive in the same cycle as the wlast handshake; it is captured in BR, so bvalid must stay held per protocol.
- Addresses wrap modulo 2^64. Byte order in rdata/wdata: byte k = bits [8k+7:8k].
- Throughput: one beat per cycle per channel when the responder is always ready.

Test Plan:
- Memory model preset mem[j]=j[7:0]; copy src=0x1000, dst=0x8000, beats=4:
  - Exactly one AR with arlen=3 and one AW with arlen=3.
  - mem[0x8000+i]==(0x1000+i)&0xFF for i<128.
  - done pulses once; err=0.
- beats=40, src=0x0, dst=0x20000:
  - Three bursts with arlen 15, 15, 7 at araddr 0x0, 0x200, 0x400; awaddr tracks dst identically.
- 4KB split, src=0x0FC0, dst=0x3000, beats=4:
  - AR#1 araddr=0x0FC0 arlen=1, AR#2 araddr=0x1000 arlen=1.
  - Destination data contiguous from 0x3000.
- beats=0:
  - done pulses within 2 cycles of accept; no arvalid or awvalid ever asserted.
- Random awready/wready/arready/rvalid/bvalid gaps on an 8-beat copy:
  - Valid/payload stable while stalled; data correct.
  - cmd_valid pulsed while busy is not accepted.
- Reset asserted during WR of beat 3: all valids drop asynchronously, cmd_ready=1 after release, and a fresh 2-beat copy then completes correctly.

Source files
------------

// File: rtl/axi_dma_copy_master.sv
// rtl/axi_dma_copy_master.sv - block copy engine: read a chunk of 32-byte beats into a buffer, write it back out
module axi_dma_copy_master #(
    parameter int MAX_BURST = 16,
    parameter int ADDR_W    = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [ADDR_W-1:0] i_cmd_src,
    input  logic [ADDR_W-1:0] i_cmd_dst,
    input  logic [23:0]       i_cmd_beats,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic              o_m_axi_awvalid,
    input  logic              i_m_axi_awready,
    output logic [ADDR_W-1:0] o_m_axi_awaddr,
    output logic [7:0]        o_m_axi_awlen,
    output logic [2:0]        o_m_axi_awsize,
    output logic              o_m_axi_wvalid,
    input  logic              i_m_axi_wready,
    output logic [255:0]      o_m_axi_wdata,
    output logic [31:0]       o_m_axi_wstrb,
    output logic              o_m_axi_wlast,
    input  logic              i_m_axi_bvalid,
    output logic              o_m_axi_bready,
    output logic              o_m_axi_arvalid,
    input  logic              i_m_axi_arready,
    output logic [ADDR_W-1:0] o_m_axi_araddr,
    output logic [7:0]        o_m_axi_arlen,
    output logic [2:0]        o_m_axi_arsize,
    input  logic              i_m_axi_rvalid,
    output logic              o_m_axi_rready,
    input  logic [255:0]      i_m_axi_rdata,
    input  logic              i_m_axi_rlast
);

    localparam int IW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_AR, S_RD, S_AW, S_WR, S_BR} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_src;
    logic [ADDR_W-1:0] r_dst;
    logic [23:0]       r_rem;
    logic [7:0]        r_len;
    logic [7:0]        r_idx;
    logic              r_done;
    logic              r_err;
    logic [255:0]      r_buf [2**IW];

    logic [23:0]       w_src_bnd;
    logic [23:0]       w_dst_bnd;
    logic [23:0]       w_chunk;
    logic [23:0]       w_cur;
    logic              w_last_beat;

    // Beats left before each address crosses a 4KB page (1..128, addresses are beat aligned).
    assign w_src_bnd   = {16'd0, 8'd128 - {1'b0, r_src[11:5]}};
    assign w_dst_bnd   = {16'd0, 8'd128 - {1'b0, r_dst[11:5]}};
    assign w_cur       = {16'd0, r_len} + 24'd1;
    assign w_last_beat = (r_idx == r_len);

    always_comb begin
        w_chunk = r_rem;
        if (w_chunk > 24'(MAX_BURST)) w_chunk = 24'(MAX_BURST);
        if (w_chunk > w_src_bnd)      w_chunk = w_src_bnd;
        if (w_chunk > w_dst_bnd)      w_chunk = w_dst_bnd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next          = r_state;
        o_cmd_ready     = 1'b0;
        o_m_axi_arvalid = 1'b0;
        o_m_axi_rready  = 1'b0;
        o_m_axi_awvalid = 1'b0;
        o_m_axi_wvalid  = 1'b0;
        o_m_axi_wlast   = 1'b0;
        o_m_axi_wdata   = '0;
        o_m_axi_bready  = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_cmd_ready = 1'b1;
                if (i_cmd_valid && i_cmd_beats != 24'd0) w_next = S_SETUP;
            end
            S_SETUP: w_next = S_AR;
            S_AR: begin
                o_m_axi_arvalid = 1'b1;
                if (i_m_axi_arready) w_next = S_RD;
            end
            S_RD: begin
                o_m_axi_rready = 1'b1;
                if (i_m_axi_rvalid && w_last_beat) w_next = S_AW;
            end
            S_AW: begin
                o_m_axi_awvalid = 1'b1;
                if (i_m_axi_awready) w_next = S_WR;
            end
            S_WR: begin
                o_m_axi_wvalid = 1'b1;
                o_m_axi_wlast  = w_last_beat;
                o_m_axi_wdata  = r_buf[r_idx[IW-1:0]];
                if (i_m_axi_wready && w_last_beat) w_next = S_BR;
            end
            S_BR: begin
                o_m_axi_bready = 1'b1;
                if (i_m_axi_bvalid) w_next = (r_rem == w_cur) ? S_IDLE : S_SETUP;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_src  <= '0;
            r_dst  <= '0;
            r_rem  <= '0;
            r_len  <= '0;
            r_idx  <= '0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: if (i_cmd_valid) begin
                    r_src  <= i_cmd_src & ~ADDR_W'(31);
                    r_dst  <= i_cmd_dst & ~ADDR_W'(31);
                    r_rem  <= i_cmd_beats;
                    r_err  <= 1'b0;
                    r_done <= (i_cmd_beats == 24'd0);
                end
                S_SETUP: begin
                    r_len <= w_chunk[7:0] - 8'd1;
                    r_idx <= '0;
                end
                S_RD: if (i_m_axi_rvalid) begin
                    // The local beat count ends the burst; a misplaced rlast is only flagged.
                    if (i_m_axi_rlast != w_last_beat) r_err <= 1'b1;
                    r_idx <= w_last_beat ? 8'd0 : r_idx + 8'd1;
                end
                S_WR: if (i_m_axi_wready && !w_last_beat) r_idx <= r_idx + 8'd1;
                S_BR: if (i_m_axi_bvalid) begin
                    r_src  <= r_src + ADDR_W'({w_cur, 5'b0});
                    r_dst  <= r_dst + ADDR_W'({w_cur, 5'b0});
                    r_rem  <= r_rem - w_cur;
                    r_done <= (r_rem == w_cur);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == S_RD && i_m_axi_rvalid) r_buf[r_idx[IW-1:0]] <= i_m_axi_rdata;
    end

    assign o_busy         = (r_state != S_IDLE);
    assign o_done         = r_done;
    assign o_err          = r_err;
    assign o_m_axi_araddr = r_src;
    assign o_m_axi_arlen  = r_len;
    assign o_m_axi_arsize = 3'd5;
    assign o_m_axi_awaddr = r_dst;
    assign o_m_axi_awlen  = r_len;
    assign o_m_axi_awsize = 3'd5;
    assign o_m_axi_wstrb  = 32'hFFFF_FFFF;

endmodule
